uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Arbitrates four byte requesters onto a single UART transmitter. A winner's
// byte is latched into tx_data0 and launched with a tx_int strobe. The arbiter
// then waits for the transmitter's busy flag (bps_start) to rise and fall, and
// inserts a guard gap before it arbitrates again. If bps_start never rises,
// err pulses and the arbiter moves on to the gap.
//
// Build option: define UART_TX_ARB_RR_EN to select round-robin arbitration,
// where the search starts after the last grant. Without it, arbitration is
// fixed priority and the lowest index wins.
module uart_tx_arbiter #(
  parameter int TX_INT_HOLD   = 2,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [7:0]  tx_data0,
  output logic        tx_int,
  input  logic        bps_start,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_START,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  // Terminal counts of the shared cycle counter, one per counting state.
  // A zero-length gap still spends its single pass-through cycle in GAP.
  localparam logic [7:0] HOLD_LAST = 8'(TX_INT_HOLD - 1);
  localparam logic [7:0] TO_LAST   = 8'(START_TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST  = 8'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [3:0]  r_ack;
  logic [7:0]  r_tx_data;
  logic        r_tx_int;
  logic        r_busy;
  logic [1:0]  r_gid;
  logic        r_err;

  logic        w_found;
  logic [1:0]  w_winner;
  logic [7:0]  w_byte;

`ifdef UART_TX_ARB_RR_EN
  logic [1:0]  w_idx;

  // Round-robin pick: scan upward from the requester after the last grant.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_gid;
    w_idx    = r_gid;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_gid + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end
`else
  // Fixed-priority pick: the lowest requesting index wins, independent of history.
  always_comb begin
    w_found  = |req;
    w_winner = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) begin
        w_winner = 2'(k);
      end
    end
  end
`endif

  assign w_byte = req_data[{w_winner, 3'b000} +: 8];

  // Frame sequencer: all outputs are registered here so they change only on clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_ack     <= 4'b0000;
      r_tx_data <= 8'h00;
      r_tx_int  <= 1'b0;
      r_busy    <= 1'b0;
      r_gid     <= 2'd3;
      r_err     <= 1'b0;
    end else begin
      r_ack <= 4'b0000;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state   <= S_LOAD;
            r_ack     <= 4'b0001 << w_winner;
            r_tx_data <= w_byte;
            r_gid     <= w_winner;
            r_tx_int  <= 1'b1;
            r_busy    <= 1'b1;
            r_cnt     <= 8'd0;
          end
        end
        S_LOAD: begin
          if (r_cnt == HOLD_LAST) begin
            r_tx_int <= 1'b0;
            r_state  <= S_WAIT_START;
            r_cnt    <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WAIT_START: begin
          if (bps_start) begin
            r_state <= S_WAIT_DONE;
            r_cnt   <= 8'd0;
          end else if (r_cnt == TO_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_GAP;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WAIT_DONE: begin
          if (!bps_start) begin
            r_state <= S_GAP;
            r_cnt   <= 8'd0;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_tx_int <= 1'b0;
          r_cnt    <= 8'd0;
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign tx_data0 = r_tx_data;
  assign tx_int   = r_tx_int;
  assign busy     = r_busy;
  assign grant_id = r_gid;
  assign err      = r_err;

endmodule
